// File: rtl/flopr_pipe_pkg.sv
// Shared types and helpers for the flopr_pipe elastic pipeline register.
package flopr_pipe_pkg;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_FLUSH = 2'd2
    } stage_op_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flopr_pipe_stage.sv
// One valid/data slot of the pipeline: load from upstream, hold on stall, or flush.
module flopr_pipe_stage
    import flopr_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  stage_op_e        op,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        case (op)
            OP_FLUSH: vld_d = 1'b0;
            OP_LOAD: begin
                vld_d = up_valid;
                if (up_valid) dat_d = up_data;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the payload is reset too so out_data is defined after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= 1'b0;
            dat_q <= RESET_VAL;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld = vld_q;
    assign dat = dat_q;

endmodule

// File: rtl/flopr_pipe.sv
// DEPTH-stage valid/ready pipeline register with back-pressure, synchronous flush and occupancy count.
module flopr_pipe
    import flopr_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [count_width(DEPTH)-1:0]    count
);

    localparam int CW = count_width(DEPTH);

    if (DEPTH < 1) begin : g_depth_check
        $error("flopr_pipe: DEPTH must be at least 1");
    end

    logic             vld [DEPTH];
    logic [WIDTH-1:0] dat [DEPTH];
    logic [DEPTH:0]   rdy;
    logic             push, pop;
    logic [CW-1:0]    count_q, count_d;

    // out_ready ripples combinationally to in_ready through every stage; long pipes see a long path here.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !vld[i] || rdy[i+1];
        end
    end

    assign in_ready  = rdy[0] && !flush;
    assign push      = in_valid && in_ready;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
    assign pop       = out_valid && out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        stage_op_e        op;

        if (i == 0) begin : g_head
            assign up_valid = push;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = vld[i-1];
            assign up_data  = dat[i-1];
        end

        assign op = flush ? OP_FLUSH : (rdy[i] ? OP_LOAD : OP_HOLD);

        flopr_pipe_stage #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .op      (op),
            .up_valid(up_valid),
            .up_data (up_data),
            .vld     (vld[i]),
            .dat     (dat[i])
        );
    end

    always_comb begin
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!reset) int'(count_q) <= DEPTH)
        else $error("flopr_pipe: count exceeds DEPTH");

endmodule

// File: tb/tb_flopr_pipe.sv
// Self-checking bench for flopr_pipe (WIDTH=8, DEPTH=2): directed table, corner sequences, random vs. queue model.
module tb_flopr_pipe;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    flopr_pipe #(
        .WIDTH    (W),
        .DEPTH    (D),
        .RESET_VAL('0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         fl;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         e_ir;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic [1:0]   e_cnt;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } beat_t;

    vec_t  tbl [15];
    beat_t q [$];

    initial begin
        // {flush, in_valid, in_data, out_ready} -> {in_ready, out_valid, out_data, count}
        tbl[0]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1};
        tbl[2]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h01, 2'd2};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 2'd2};
        tbl[4]  = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h03, 2'd1};
        tbl[5]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h03, 2'd2};
        tbl[6]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h03, 2'd2};
        tbl[7]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h03, 2'd2};
        tbl[8]  = '{1'b1, 1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 8'h04, 2'd2};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[10] = '{1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h07, 2'd1};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h07, 2'd1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};

        // Reset held with an active upstream beat.
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count",     32'(count),     0);
        check("rst_out_data",  32'(out_data),  32'h00);
        check("rst_in_ready",  32'(in_ready),  1);
        reset = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("rel_out_valid_1", 32'(out_valid), 0);
        check("rel_count_1",     32'(count),     1);
        @(negedge clk);
        check("rel_out_valid_2", 32'(out_valid), 1);
        check("rel_out_data_2",  32'(out_data),  32'hAA);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: streaming, back-pressure, flush.
        for (int i = 0; i < 15; i++) begin
            flush     = tbl[i].fl;
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            check($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("tbl%0d_count", i),     32'(count),     32'(tbl[i].e_cnt));
            if (tbl[i].e_ov)
                check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            @(posedge clk);
            #1;
        end
        flush = 1'b0;

        // Full pipe with simultaneous pop and push.
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
        @(posedge clk); #1 in_data = 8'h22;
        @(posedge clk); #1 in_data = 8'h55; out_ready = 1'b1;
        @(negedge clk);
        check("pp_count_full", 32'(count),    2);
        check("pp_in_ready",   32'(in_ready), 1);
        check("pp_out_data0",  32'(out_data), 32'h11);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("pp_count_same", 32'(count),    2);
        check("pp_out_data1",  32'(out_data), 32'h22);
        @(negedge clk);
        check("pp_out_valid2", 32'(out_valid), 1);
        check("pp_out_data2",  32'(out_data),  32'h55);
        @(posedge clk); #1 out_ready = 1'b0;

        // Asynchronous reset pulse while stalled full.
        in_valid = 1'b1; in_data = 8'h66;
        @(posedge clk); #1 in_data = 8'h77;
        @(posedge clk); #1 in_data = 8'h88;
        @(negedge clk);
        check("ar_count_full", 32'(count),    2);
        check("ar_in_ready",   32'(in_ready), 0);
        #1 reset = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 0);
        check("ar_count",     32'(count),     0);
        check("ar_out_data",  32'(out_data),  32'h00);
        check("ar_in_ready",  32'(in_ready),  1);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against a beat-queue model; the pipe is empty here.
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit    e_ov, e_ir, do_pop;
            int    limit;
            beat_t nq [$];

            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = W'($urandom);

            e_ov   = (q.size() > 0) && (q[0].pos == D - 1);
            do_pop = e_ov && out_ready;
            nq     = {};
            limit  = D;
            foreach (q[k]) begin
                beat_t b;
                b = q[k];
                if (k == 0 && do_pop) continue;
                b.pos = (b.pos + 1 < limit - 1) ? b.pos + 1 : limit - 1;
                limit = b.pos;
                nq.push_back(b);
            end
            e_ir = !flush && (nq.size() == 0 || nq[nq.size()-1].pos != 0);

            @(negedge clk);
            check("rnd_in_ready",  32'(in_ready),  32'(e_ir));
            check("rnd_out_valid", 32'(out_valid), 32'(e_ov));
            check("rnd_count",     32'(count),     32'(q.size()));
            if (e_ov) check("rnd_out_data", 32'(out_data), 32'(q[0].d));

            if (flush) begin
                q.delete();
            end else begin
                if (in_valid && e_ir) begin
                    beat_t nb;
                    nb.d   = in_data;
                    nb.pos = 0;
                    nq.push_back(nb);
                end
                q = nq;
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
